j4_io_hub: RTL

- Responder side of the j4 barrel-CPU IO bus: decodes io_rd/io_wr strobes tagged by io_slot and returns registered read data on io_din.
- Provides slot identification, per-destination inter-thread mailbox FIFOs, per-slot watchdogs and software kill requests.
- Drives j4's kill_slot_rq input.
- Sits beside j4 in the top level, in parallel with the other IO peripherals; its io_din is ORed into the j4 read path.

---
 rtl/j4_io_hub_if.sv | 28 ++
 rtl/j4_io_hub.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/j4_io_hub_if.sv
// ============================================================================
// Module : j4_io_hub_if
// Brief  : j4 IO bus bundle between the CPU (master) and the io hub (slave).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface j4_io_hub_if;
    logic        io_rd;
    logic        io_wr;
    logic [1:0]  io_slot;
    logic [15:0] mem_addr;
    logic [15:0] dout;
    logic [15:0] io_din;
    logic [3:0]  kill_slot_rq;

    modport master (
        output io_rd, io_wr, io_slot, mem_addr, dout,
        input  io_din, kill_slot_rq
    );

    modport slave (
        input  io_rd, io_wr, io_slot, mem_addr, dout,
        output io_din, kill_slot_rq
    );
endinterface

`default_nettype wire

// File: rtl/j4_io_hub.sv
// ============================================================================
// Module : j4_io_hub
// Brief  : j4 IO responder: slot id, inter-thread mailboxes, watchdogs, kills.
//          Optional cycle timestamp at 0x1001 via macro IO_HUB_TIMESTAMP_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module j4_io_hub #(
    parameter int MBOX_DEPTH = 4,
    parameter int WDOG_W     = 16
) (
    input  wire logic   clk,
    input  wire logic   reset,
    j4_io_hub_if.slave  bus
);

    localparam int            c_PTR_W   = $clog2(MBOX_DEPTH);
    localparam logic [4:0]    c_FULL    = 5'(MBOX_DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [WDOG_W-1:0]  c_WD_ONE  = WDOG_W'(1);
    localparam logic [WDOG_W-1:0]  c_WD_ZERO = '0;

    localparam logic [15:0] c_A_SLOTID = 16'h1000;
    localparam logic [15:0] c_A_TSTAMP = 16'h1001;
    localparam logic [15:0] c_A_MBOX   = 16'h2000;
    localparam logic [15:0] c_A_DEST   = 16'h2001;
    localparam logic [15:0] c_A_STATUS = 16'h2002;
    localparam logic [15:0] c_A_WDOG   = 16'h4000;
    localparam logic [15:0] c_A_KILL   = 16'h4001;

    logic [15:0]        r_io_din;
    logic [3:0]         r_kill;
    logic [15:0]        r_mem  [4][MBOX_DEPTH];
    logic [c_PTR_W-1:0] r_wptr [4];
    logic [c_PTR_W-1:0] r_rptr [4];
    logic [4:0]         r_cnt  [4];
    logic [3:0]         r_ovf;
    logic [1:0]         r_dest [4];
    logic [WDOG_W-1:0]  r_wdog [4];

    logic [1:0]   w_s;
    logic         w_rd;
    logic         w_wr;
    logic [3:0]   w_push;
    logic [3:0]   w_pop;
    logic [3:0]   w_stat_rd;
    logic [3:0]   w_dest_wr;
    logic [3:0]   w_wd_ld;
    logic [3:0]   w_full;
    logic [3:0]   w_empty;
    logic [3:0]   w_expire;
    logic [3:0]   w_sw_kill;
    logic [15:0]  w_rdata;
    logic [15:0]  w_ts;

`ifdef IO_HUB_TIMESTAMP_EN
    logic [15:0] r_ts;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ts <= 16'd0;
        end else begin
            r_ts <= r_ts + 16'd1;
        end
    end

    assign w_ts = r_ts;
`else
    assign w_ts = 16'd0;
`endif

    // A slot whose kill pulse is live has all of its own accesses ignored.
    always_comb begin
        w_s  = bus.io_slot;
        w_rd = bus.io_rd && !r_kill[w_s];
        w_wr = bus.io_wr && !r_kill[w_s];
    end

    always_comb begin
        w_push    = '0;
        w_pop     = '0;
        w_stat_rd = '0;
        w_dest_wr = '0;
        w_wd_ld   = '0;
        w_full    = '0;
        w_empty   = '0;
        w_expire  = '0;
        for (int n = 0; n < 4; n++) begin
            w_full[n]    = (r_cnt[n] == c_FULL);
            w_empty[n]   = (r_cnt[n] == 5'd0);
            w_push[n]    = w_wr && (bus.mem_addr == c_A_MBOX) &&
                           (r_dest[w_s] == 2'(n)) && !r_kill[n];
            w_pop[n]     = w_rd && (bus.mem_addr == c_A_MBOX) &&
                           (w_s == 2'(n)) && !w_empty[n];
            w_stat_rd[n] = w_rd && (bus.mem_addr == c_A_STATUS) && (w_s == 2'(n));
            w_dest_wr[n] = w_wr && (bus.mem_addr == c_A_DEST) && (w_s == 2'(n));
            w_wd_ld[n]   = w_wr && (bus.mem_addr == c_A_WDOG) && (w_s == 2'(n));
            // A load landing on the expiry edge replaces the countdown silently.
            w_expire[n]  = (r_wdog[n] == c_WD_ONE) && !w_wd_ld[n] && !r_kill[n];
        end
        w_sw_kill = (w_wr && (bus.mem_addr == c_A_KILL)) ? bus.dout[3:0] : 4'b0000;
    end

    always_comb begin
        w_rdata = 16'd0;
        case (bus.mem_addr)
            c_A_SLOTID: w_rdata = {14'b0, w_s};
            c_A_TSTAMP: w_rdata = w_ts;
            c_A_MBOX:   w_rdata = w_empty[w_s] ? 16'd0 : r_mem[w_s][r_rptr[w_s]];
            c_A_DEST:   w_rdata = {14'b0, r_dest[w_s]};
            c_A_STATUS: w_rdata = {7'b0, r_ovf[w_s], r_cnt[w_s], 1'b0,
                                   w_full[w_s], w_empty[w_s]};
            c_A_WDOG:   w_rdata = 16'(r_wdog[w_s]);
            default:    w_rdata = 16'd0;
        endcase
    end

    // Mailbox storage carries no reset; occupancy lives in the pointers/counts.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (w_push[n] && !w_full[n]) begin
                r_mem[n][r_wptr[n]] <= bus.dout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_io_din <= 16'd0;
            r_kill   <= 4'b0000;
            r_ovf    <= 4'b0000;
            for (int n = 0; n < 4; n++) begin
                r_wptr[n] <= '0;
                r_rptr[n] <= '0;
                r_cnt[n]  <= 5'd0;
                r_dest[n] <= 2'(n);
                r_wdog[n] <= c_WD_ZERO;
            end
        end else begin
            r_kill <= w_sw_kill | w_expire;
            if (bus.io_rd) begin
                r_io_din <= r_kill[w_s] ? 16'd0 : w_rdata;
            end
            for (int n = 0; n < 4; n++) begin
                if (r_kill[n]) begin
                    r_wptr[n] <= '0;
                    r_rptr[n] <= '0;
                    r_cnt[n]  <= 5'd0;
                    r_ovf[n]  <= 1'b0;
                    r_dest[n] <= 2'(n);
                    r_wdog[n] <= c_WD_ZERO;
                end else begin
                    if (w_push[n]) begin
                        if (w_full[n]) begin
                            r_ovf[n] <= 1'b1;
                        end else begin
                            r_wptr[n] <= r_wptr[n] + c_PTR_ONE;
                            r_cnt[n]  <= r_cnt[n] + 5'd1;
                        end
                    end
                    if (w_pop[n]) begin
                        r_rptr[n] <= r_rptr[n] + c_PTR_ONE;
                        r_cnt[n]  <= r_cnt[n] - 5'd1;
                    end
                    if (w_stat_rd[n]) begin
                        r_ovf[n] <= 1'b0;
                    end
                    if (w_dest_wr[n]) begin
                        r_dest[n] <= bus.dout[1:0];
                    end
                    if (w_wd_ld[n]) begin
                        r_wdog[n] <= WDOG_W'(bus.dout);
                    end else if (r_wdog[n] != c_WD_ZERO) begin
                        r_wdog[n] <= r_wdog[n] - c_WD_ONE;
                    end
                end
            end
        end
    end

    assign bus.io_din       = r_io_din;
    assign bus.kill_slot_rq = r_kill;

endmodule

`default_nettype wire
